mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1, memory read latency in cycles after the access cycle; legal range 1..15.
REQ-002 Parameter AW, default 64, address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 if_req  input  1  instruction-fetch request, held until if_done.
REQ-006 if_addr  input  AW  fetch address, stable while if_req high.
REQ-007 if_gnt  output  1  fetch port owns memory.
REQ-008 if_done  output  1  one-cycle fetch completion pulse.
REQ-009 if_rdata  output  32  fetched instruction (low 32 bits of captured word).
REQ-010 dm_req  input  1  data request, held until dm_done.
REQ-011 dm_we  input  1  1 = store, 0 = load; stable with dm_req.
REQ-012 dm_addr  input  AW  data address.
REQ-013 dm_wdata  input  64  store data.
REQ-014 dm_gnt  output  1  data port owns memory.
REQ-015 dm_done  output  1  one-cycle data completion pulse.
REQ-016 dm_rdata  output  64  load result.
REQ-017 mem_en  output  1  memory access strobe.
REQ-018 mem_we  output  1  memory write enable, only ever high with mem_en.
REQ-019 mem_addr  output  AW  latched winner address.
REQ-020 mem_wdata  output  64  latched store data.
REQ-021 mem_rdata  input  64  memory read data, valid MEM_LAT cycles after mem_en cycle.

Function
REQ-022 FSM states IDLE, ACCESS, WAIT, DONE; all outputs registered.
REQ-023 IDLE: if any req, latch winner, addr, we, wdata; go ACCESS; else stay.
REQ-024 ACCESS: exactly one cycle, mem_en=1, mem_we=latched we; load WAIT counter with MEM_LAT; go WAIT.
REQ-025 WAIT: decrement counter; on last WAIT cycle capture mem_rdata into winner rdata register (loads and fetches only); go DONE.
REQ-026 DONE: one cycle, winner done=1; go IDLE unconditionally.
REQ-027 Latency req-seen-in-IDLE to done = MEM_LAT+2 cycles; stores same latency as loads.
REQ-028 Requester drops or changes req on the edge where done is sampled high; next arbitration occurs in following IDLE cycle (one access per MEM_LAT+3 cycles max).
REQ-029 gnt of winner high in ACCESS, WAIT, DONE; never both gnt high.
REQ-030 Single requester always wins; simultaneous requests resolved per REQ-036/037.
REQ-031 if_rdata/dm_rdata hold last captured value until next capture for that port.
REQ-032 Req deasserted mid-transaction: access completes, done still pulses, no abort.
REQ-033 Fetch port is read-only; mem_we never 1 for fetch winner.

Reset
REQ-034 rst_n low: state IDLE immediately; all outputs 0, rdata registers 0, counter 0, last-winner flag = fetch.
REQ-035 Reset mid-transaction abandons access, no done pulse; first post-reset arbitration in first IDLE cycle after rst_n rises.

Configuration
REQ-036 ARB_RR_EN defined: round-robin; on simultaneous requests the port not in last-winner flag wins; flag updated on every ACCESS entry.
REQ-037 ARB_RR_EN undefined: fixed priority, data port always wins ties; last-winner flag absent.

Verification
REQ-038 MEM_LAT=1, fetch only, if_addr=0x0, mem_rdata=0x00000000_00410333 in WAIT -> mem_en cycle 1, if_done cycle 3, if_rdata=0x00410333.
REQ-039 MEM_LAT=3, dm store addr=0x40 wdata=0xDEAD_BEEF -> one-cycle mem_en=mem_we=1, mem_addr=0x40, dm_done 5 cycles after request.
REQ-040 Both req held continuously, fixed priority -> dm wins every arbitration, if_gnt never high; with ARB_RR_EN -> grants alternate dm, if, dm, if.
REQ-041 rst_n low during WAIT -> all outputs 0 same cycle, no done; after release pending if_req completes in MEM_LAT+2 cycles.
REQ-042 dm load then immediate fetch -> dm_rdata retained unchanged after if_done; gnt signals never overlap.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-ported memory between an instruction-fetch port (read
//   only, 32-bit result) and a data port (load/store, 64-bit). Each granted
//   request runs a fixed IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> DONE
//   sequence, so request-to-done latency is MEM_LAT+2 cycles for loads,
//   stores and fetches alike. All outputs are registered.
//
//   Build option:
//     ARB_RR_EN  defined   : round-robin on simultaneous requests, using a
//                            last-winner flag that resets to "fetch".
//                undefined : fixed priority, the data port wins ties.
//
// Parameters
//   MEM_LAT  memory read latency after the access cycle (legal 1..15)
//   AW       address width
//
// Ports
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_if_req, i_if_addr            fetch request / address (held until done)
//   o_if_gnt, o_if_done, o_if_rdata fetch grant, done pulse, instruction
//   i_dm_req, i_dm_we, i_dm_addr,
//   i_dm_wdata                     data request, store flag, address, data
//   o_dm_gnt, o_dm_done, o_dm_rdata data grant, done pulse, load result
//   o_mem_en, o_mem_we, o_mem_addr,
//   o_mem_wdata                    memory strobe, write enable, address, data
//   i_mem_rdata                    memory read data (MEM_LAT after o_mem_en)
//
// States
//   ST_IDLE   | no transaction; arbitrate and latch the winner's request
//   ST_ACCESS | one-cycle memory strobe (o_mem_en, o_mem_we)
//   ST_WAIT   | count down MEM_LAT cycles, capture read data on the last one
//   ST_DONE   | one-cycle done pulse to the winner, then back to idle
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int AW      = 64
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_gnt,
  output logic          o_if_done,
  output logic [31:0]   o_if_rdata,
  input  logic          i_dm_req,
  input  logic          i_dm_we,
  input  logic [AW-1:0] i_dm_addr,
  input  logic [63:0]   i_dm_wdata,
  output logic          o_dm_gnt,
  output logic          o_dm_done,
  output logic [63:0]   o_dm_rdata,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [63:0]   o_mem_wdata,
  input  logic [63:0]   i_mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] LP_LAT = 4'(MEM_LAT);

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_if_gnt;
  logic            r_dm_gnt;
  logic            r_if_done;
  logic            r_dm_done;
  logic            r_mem_en;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [63:0]     r_mem_wdata;
  logic [31:0]     r_if_rdata;
  logic [63:0]     r_dm_rdata;
  logic [3:0]      r_cnt;
  logic            r_win_dm;
  logic            r_op_we;

  logic            w_if_gnt_nxt;
  logic            w_dm_gnt_nxt;
  logic            w_if_done_nxt;
  logic            w_dm_done_nxt;
  logic            w_mem_en_nxt;
  logic            w_mem_we_nxt;
  logic            w_cap;
  logic            w_any_req;
  logic            w_arb;
  logic            w_pick_dm;
  logic            w_cnt_tc;

  assign w_any_req = i_if_req | i_dm_req;
  assign w_arb     = (r_state == ST_IDLE) & w_any_req;
  assign w_cnt_tc  = (r_cnt == 4'd1);

`ifdef ARB_RR_EN
  // 1 = data port won the most recent arbitration
  logic r_last_dm;

  // On a tie the port that did not win last time goes first.
  assign w_pick_dm = i_dm_req & (~i_if_req | ~r_last_dm);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_dm <= 1'b0;
    end else if (w_arb) begin
      r_last_dm <= w_pick_dm;
    end
  end
`else
  assign w_pick_dm = i_dm_req;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the next value of every registered control output.
  always_comb begin
    w_state_nxt   = r_state;
    w_if_gnt_nxt  = r_if_gnt;
    w_dm_gnt_nxt  = r_dm_gnt;
    w_if_done_nxt = 1'b0;
    w_dm_done_nxt = 1'b0;
    w_mem_en_nxt  = 1'b0;
    w_mem_we_nxt  = 1'b0;
    w_cap         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt  = ST_ACCESS;
          w_if_gnt_nxt = ~w_pick_dm;
          w_dm_gnt_nxt = w_pick_dm;
          w_mem_en_nxt = 1'b1;
          // fetches never write, whatever i_dm_we happens to be
          w_mem_we_nxt = w_pick_dm & i_dm_we;
        end
      end
      ST_ACCESS: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_cnt_tc) begin
          w_state_nxt   = ST_DONE;
          w_if_done_nxt = ~r_win_dm;
          w_dm_done_nxt = r_win_dm;
          w_cap         = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt  = ST_IDLE;
        w_if_gnt_nxt = 1'b0;
        w_dm_gnt_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_if_gnt    <= 1'b0;
      r_dm_gnt    <= 1'b0;
      r_if_done   <= 1'b0;
      r_dm_done   <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_cnt       <= '0;
      r_win_dm    <= 1'b0;
      r_op_we     <= 1'b0;
    end else begin
      r_if_gnt  <= w_if_gnt_nxt;
      r_dm_gnt  <= w_dm_gnt_nxt;
      r_if_done <= w_if_done_nxt;
      r_dm_done <= w_dm_done_nxt;
      r_mem_en  <= w_mem_en_nxt;
      r_mem_we  <= w_mem_we_nxt;

      if (w_arb) begin
        r_win_dm   <= w_pick_dm;
        r_op_we    <= w_pick_dm & i_dm_we;
        r_mem_addr <= w_pick_dm ? i_dm_addr : i_if_addr;
        if (w_pick_dm) begin
          r_mem_wdata <= i_dm_wdata;
        end
      end

      if (r_state == ST_ACCESS) begin
        r_cnt <= LP_LAT;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end

      // Stores leave the load result untouched.
      if (w_cap) begin
        if (!r_win_dm) begin
          r_if_rdata <= i_mem_rdata[31:0];
        end else if (!r_op_we) begin
          r_dm_rdata <= i_mem_rdata;
        end
      end
    end
  end

  assign o_if_gnt    = r_if_gnt;
  assign o_dm_gnt    = r_dm_gnt;
  assign o_if_done   = r_if_done;
  assign o_dm_done   = r_dm_done;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_rdata  = r_dm_rdata;

endmodule
